spike_event_framer: RTL and testbench



---
 rtl/spike_event_framer.sv | 224 ++++++++++++++++++++++
 tb/tb_spike_event_framer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spike_event_framer.sv
`default_nettype none
// ============================================================================
// Module      : spike_event_framer
// Description : Turns spike-detector flags into timestamped peak events.
//               On each onset, a peak-magnitude search runs over WIN valid
//               samples. The result {onset timestamp, signed peak sample} is
//               pushed into a small FIFO. A refractory dead time of REFRACT
//               valid samples follows every window. Events that find the FIFO
//               full are dropped and counted in a saturating counter.
// Ports       :
//   clk           clock
//   rst           asynchronous active-high reset
//   sample_valid  qualifies data_in / spike_in for this cycle
//   data_in       signed sample, aligned with spike_in
//   spike_in      detector flag for this sample
//   ev_valid      FIFO head valid
//   ev_ready      consumer accepts head
//   ev_timestamp  sample index of the event onset (head entry)
//   ev_peak       signed sample of largest magnitude in the window (head)
//   drop_count    saturating count of events lost to a full FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module spike_event_framer #(
  parameter int DATA_W     = 16,
  parameter int TS_W       = 24,
  parameter int WIN        = 8,
  parameter int REFRACT    = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     sample_valid,
  input  logic signed [DATA_W-1:0] data_in,
  input  logic                     spike_in,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [TS_W-1:0]          ev_timestamp,
  output logic [DATA_W-1:0]        ev_peak,
  output logic [7:0]               drop_count
);

  localparam int         C_ADDR_W  = $clog2(FIFO_DEPTH);
  localparam logic [7:0]  C_WIN     = 8'(WIN);
  localparam logic [15:0] C_REFRACT = 16'(REFRACT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_REFRACT = 2'd2
  } state_t;

  // Saturating magnitude: the most negative value maps to the largest
  // positive value, so it ties with +max and the earlier sample is kept.
  function automatic logic [DATA_W-2:0] mag(input logic [DATA_W-1:0] x);
    logic [DATA_W-1:0] neg;
    neg = '0;
    if (!x[DATA_W-1]) begin
      mag = x[DATA_W-2:0];
    end else if (x[DATA_W-2:0] == '0) begin
      mag = '1;
    end else begin
      neg = -x;
      mag = neg[DATA_W-2:0];
    end
  endfunction

  // --------------------------------------------------------------------------
  // Framing state
  // --------------------------------------------------------------------------
  state_t            state_q, state_d;
  logic [TS_W-1:0]   cnt_q, cnt_d;
  logic [TS_W-1:0]   ts_q, ts_d;
  logic [DATA_W-1:0] peak_q, peak_d;
  logic [7:0]        win_cnt_q, win_cnt_d;
  logic [15:0]       ref_cnt_q, ref_cnt_d;
  logic [7:0]        drop_count_q, drop_count_d;

  // --------------------------------------------------------------------------
  // FIFO state (pointers carry one extra bit to separate full from empty)
  // --------------------------------------------------------------------------
  logic [C_ADDR_W:0] wr_ptr_q, wr_ptr_d;
  logic [C_ADDR_W:0] rd_ptr_q, rd_ptr_d;
  logic [TS_W-1:0]   mem_ts_q   [FIFO_DEPTH];
  logic [DATA_W-1:0] mem_peak_q [FIFO_DEPTH];

  logic              push_req;
  logic [TS_W-1:0]   push_ts;
  logic [DATA_W-1:0] push_peak;
  logic [DATA_W-1:0] peak_upd;
  logic [7:0]        win_next;
  logic [15:0]       ref_next;
  logic              fifo_empty;
  logic              fifo_full;
  logic              do_pop;
  logic              do_push;
  logic              do_drop;

  assign win_next = win_cnt_q + 8'd1;
  assign ref_next = ref_cnt_q + 16'd1;

  // Strictly-greater comparison keeps the earliest sample on a tie.
  assign peak_upd = (mag(data_in) > mag(peak_q)) ? data_in : peak_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ts_d      = ts_q;
    peak_d    = peak_q;
    win_cnt_d = win_cnt_q;
    ref_cnt_d = ref_cnt_q;
    push_req  = 1'b0;
    push_ts   = ts_q;
    push_peak = peak_q;

    if (sample_valid) begin
      cnt_d = cnt_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (spike_in) begin
            ts_d      = cnt_q;
            peak_d    = data_in;
            win_cnt_d = 8'd1;
            if (C_WIN == 8'd1) begin
              // Single-sample window closes on the onset sample itself.
              push_req  = 1'b1;
              push_ts   = cnt_q;
              push_peak = data_in;
              ref_cnt_d = 16'd0;
              state_d   = (C_REFRACT == 16'd0) ? S_IDLE : S_REFRACT;
            end else begin
              state_d = S_CAPTURE;
            end
          end
        end
        S_CAPTURE: begin
          peak_d    = peak_upd;
          win_cnt_d = win_next;
          if (win_next == C_WIN) begin
            push_req  = 1'b1;
            push_ts   = ts_q;
            push_peak = peak_upd;
            ref_cnt_d = 16'd0;
            state_d   = (C_REFRACT == 16'd0) ? S_IDLE : S_REFRACT;
          end
        end
        S_REFRACT: begin
          ref_cnt_d = ref_next;
          if (ref_next == C_REFRACT) begin
            state_d = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // FIFO control
  // --------------------------------------------------------------------------
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[C_ADDR_W] != rd_ptr_q[C_ADDR_W]) &&
                      (wr_ptr_q[C_ADDR_W-1:0] == rd_ptr_q[C_ADDR_W-1:0]);
  assign do_pop     = !fifo_empty && ev_ready;
  // A pop in the same cycle frees the slot a full FIFO needs.
  assign do_push    = push_req && (!fifo_full || do_pop);
  assign do_drop    = push_req && fifo_full && !do_pop;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    drop_count_d = drop_count_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_drop && (drop_count_q != 8'hFF)) begin
      drop_count_d = drop_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      ts_q         <= '0;
      peak_q       <= '0;
      win_cnt_q    <= '0;
      ref_cnt_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ts_q         <= ts_d;
      peak_q       <= peak_d;
      win_cnt_q    <= win_cnt_d;
      ref_cnt_q    <= ref_cnt_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage needs no reset: the head is only visible while the FIFO is
  // non-empty, and the pointers are reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_ts_q[wr_ptr_q[C_ADDR_W-1:0]]   <= push_ts;
      mem_peak_q[wr_ptr_q[C_ADDR_W-1:0]] <= push_peak;
    end
  end

  assign ev_valid     = !fifo_empty;
  assign ev_timestamp = fifo_empty ? '0 : mem_ts_q[rd_ptr_q[C_ADDR_W-1:0]];
  assign ev_peak      = fifo_empty ? '0 : mem_peak_q[rd_ptr_q[C_ADDR_W-1:0]];
  assign drop_count   = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_spike_event_framer.sv
`default_nettype none
// ============================================================================
// Module      : tb_spike_event_framer
// Description : Bench for spike_event_framer. Directed scenarios and random
//               traffic are compared against a sample-index based event model
//               and a queue standing in for the event FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spike_event_framer;

  localparam int DATA_W     = 16;
  localparam int TS_W       = 24;
  localparam int WIN        = 8;
  localparam int REFRACT    = 32;
  localparam int FIFO_DEPTH = 8;

  logic                     clk = 1'b0;
  logic                     rst;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] data_in;
  logic                     spike_in;
  logic                     ev_valid;
  logic                     ev_ready;
  logic [TS_W-1:0]          ev_timestamp;
  logic [DATA_W-1:0]        ev_peak;
  logic [7:0]               drop_count;

  spike_event_framer #(
    .DATA_W(DATA_W), .TS_W(TS_W), .WIN(WIN), .REFRACT(REFRACT),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .data_in(data_in),
    .spike_in(spike_in), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_timestamp(ev_timestamp), .ev_peak(ev_peak), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    longint ts;
    int     peak;
  } ev_t;

  ev_t    m_q[$];      // expected FIFO contents
  ev_t    log_q[$];    // events actually handed over by the DUT
  longint m_idx;       // valid samples seen since reset
  longint m_elig;      // first index allowed to start a new window
  longint m_end;       // index of the sample closing the open window
  bit     m_open;
  longint m_ts;
  int     m_peak;
  int     m_drop;

  function automatic int magn(input int x);
    int m;
    m = (x < 0) ? -x : x;
    if (m > (1 << (DATA_W-1)) - 1) m = (1 << (DATA_W-1)) - 1;
    return m;
  endfunction

  task automatic model_reset();
    m_q.delete();
    log_q.delete();
    m_idx = 0; m_elig = 0; m_end = 0; m_open = 0;
    m_ts = 0; m_peak = 0; m_drop = 0;
  endtask

  // Called at a negedge: drives one cycle, predicts the next edge, checks.
  task automatic step(input bit sv, input bit spk, input int d, input bit rdy);
    bit  pop, push;
    int  ds;
    ev_t e;
    sample_valid = sv;
    spike_in     = spk;
    data_in      = DATA_W'(d);
    ev_ready     = rdy;
    ds   = int'(data_in);
    pop  = (m_q.size() > 0) && rdy;
    push = 0;
    if (ev_valid && rdy) begin
      e.ts = longint'(ev_timestamp); e.peak = int'($signed(ev_peak));
      log_q.push_back(e);
    end
    if (sv) begin
      if (!m_open && m_idx >= m_elig && spk) begin
        m_open = 1; m_ts = m_idx % (longint'(1) << TS_W); m_peak = ds;
        m_end  = m_idx + WIN - 1;
        m_elig = m_idx + WIN + REFRACT;
      end else if (m_open && magn(ds) > magn(m_peak)) begin
        m_peak = ds;
      end
      if (m_open && m_idx == m_end) begin
        push = 1; m_open = 0;
      end
      m_idx++;
    end
    if (pop) void'(m_q.pop_front());
    if (push) begin
      if (m_q.size() < FIFO_DEPTH) begin
        e.ts = m_ts; e.peak = m_peak;
        m_q.push_back(e);
      end else if (m_drop < 255) begin
        m_drop++;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("ev_valid", ev_valid, (m_q.size() != 0));
    if (m_q.size() != 0) begin
      check("ev_timestamp", ev_timestamp, m_q[0].ts);
      check("ev_peak", int'($signed(ev_peak)), m_q[0].peak);
    end
    check("drop_count", drop_count, m_drop);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic longint log_ts(input int i);
    return (i < log_q.size()) ? log_q[i].ts : -1;
  endfunction

  function automatic int rnd_data();
    case ($urandom_range(7))
      0: return -32768;
      1: return 32767;
      2: return -32767;
      default: return int'($signed(16'($urandom)));
    endcase
  endfunction

  initial begin
    int seq[8];
    int p_sv, p_spk, p_rdy;
    rst = 1'b1; sample_valid = 0; data_in = '0; spike_in = 0; ev_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ev_valid", ev_valid, 0);
    check("rst_ev_timestamp", ev_timestamp, 0);
    check("rst_ev_peak", ev_peak, 0);
    check("rst_drop_count", drop_count, 0);
    rst = 1'b0;

    // Isolated spike at index 100.
    seq = '{10, 20, -300, 50, 299, 0, 0, 0};
    for (int i = 0; i < 100; i++) step(1, 0, rnd_data(), 1);
    for (int i = 0; i < 8; i++) step(1, (i == 0), seq[i], 1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 1);
    check("iso_count", log_q.size(), 1);
    check("iso_ts", log_ts(0), 100);
    if (log_q.size() > 0) check("iso_peak", log_q[0].peak, -300);

    // Spike held high: refractory spacing.
    do_reset();
    for (int i = 0; i < 100; i++) step(1, 1, rnd_data(), 1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 1);
    check("refr_count", log_q.size(), 3);
    check("refr_ts0", log_ts(0), 0);
    check("refr_ts1", log_ts(1), 40);
    check("refr_ts2", log_ts(2), 80);

    // Tie with saturated magnitude.
    do_reset();
    step(1, 1, -32768, 1);
    step(1, 0, 32767, 1);
    step(1, 0, -32767, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
    check("tie_count", log_q.size(), 1);
    if (log_q.size() > 0) check("tie_peak", log_q[0].peak, -32768);

    // Backpressure: 10 events into an 8-deep FIFO.
    do_reset();
    for (int k = 0; k < 10; k++) begin
      step(1, 1, rnd_data(), 0);
      for (int i = 0; i < 39; i++) step(1, 0, rnd_data(), 0);
    end
    check("bp_drop", drop_count, 2);
    // 11th event closes while full, with one pop on that same cycle.
    step(1, 1, rnd_data(), 0);
    for (int i = 0; i < 6; i++) step(1, 0, rnd_data(), 0);
    step(1, 0, rnd_data(), 1);
    for (int i = 0; i < 32; i++) step(1, 0, rnd_data(), 0);
    check("bp_drop_pushpop", drop_count, 2);
    for (int i = 0; i < 60; i++) step($urandom_range(1), 0, rnd_data(), $urandom_range(1));
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1);
    check("bp_count", log_q.size(), 9);
    for (int i = 0; i < 9; i++)
      check("bp_order", log_ts(i), (i < 8) ? 40 * i : 400);

    // Async reset mid-capture with 3 events queued.
    for (int k = 0; k < 3; k++) begin
      step(1, 1, rnd_data(), 0);
      for (int i = 0; i < 39; i++) step(1, 0, rnd_data(), 0);
    end
    step(1, 1, rnd_data(), 0);
    for (int i = 0; i < 3; i++) step(1, 0, rnd_data(), 0);
    check("pre_rst_valid", ev_valid, 1);
    #2 rst = 1'b1;
    #1;
    check("arst_ev_valid", ev_valid, 0);
    check("arst_drop_count", drop_count, 0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1, 0, rnd_data(), 1);
    step(1, 1, rnd_data(), 1);
    for (int i = 0; i < 10; i++) step(1, 0, rnd_data(), 1);
    check("arst_ts", log_ts(0), 5);

    // Gapped input during a window.
    do_reset();
    for (int i = 0; i < 3; i++) step(1, 0, rnd_data(), 1);
    for (int i = 0; i < 16; i++) step((i % 2) == 0, (i == 0), rnd_data(), 1);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1);
    check("gap_count", log_q.size(), 1);
    check("gap_ts", log_ts(0), 3);

    // Random traffic in phases of varying density and backpressure.
    do_reset();
    for (int ph = 0; ph < 12; ph++) begin
      p_sv  = $urandom_range(30, 100);
      p_spk = $urandom_range(2, 60);
      p_rdy = (ph % 3 == 0) ? 5 : $urandom_range(10, 100);
      for (int i = 0; i < 500; i++)
        step($urandom_range(99) < p_sv, $urandom_range(99) < p_spk,
             rnd_data(), $urandom_range(99) < p_rdy);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: got no finish, expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
